// File: rtl/nbit_pipe_addsub_if.sv
// ---------------------------------------------------------------------------
// nbit_pipe_addsub_if
//   Bundles the operation request and result channels of nbit_pipe_addsub.
//
//   Request channel (master -> slave):
//     in_valid   operation offered
//     a, b       N-bit operands
//     sub        1 = A - B, 0 = A + B + cin
//     cin        carry-in for add; ignored on subtract
//   Request back-pressure (slave -> master):
//     in_ready   unit accepts this cycle
//   Result channel (slave -> master):
//     out_valid  result presented
//     sum        N-bit result
//     cout       carry-out (on subtract, 1 = no borrow)
//     zero, neg, ovf  status flags
//   Result back-pressure (master -> slave):
//     out_ready  consumer accepts the result
// ---------------------------------------------------------------------------
interface nbit_pipe_addsub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, zero, neg, ovf
    );
endinterface

// File: rtl/nbit_pipe_addsub.sv
// ---------------------------------------------------------------------------
// nbit_pipe_addsub
//   Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES
//   segments of SEG = N/STAGES bits; stage k ripples only segment k, using
//   the carry registered by stage k-1. One operation per cycle is accepted
//   through a valid/ready handshake with full back-pressure, and results
//   leave in issue order.
//
// Parameters
//   N       operand/result width (N >= 2)
//   STAGES  pipeline depth / number of carry segments (N % STAGES == 0)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset (clears all stage valid bits)
//   p       nbit_pipe_addsub_if.slave: in_valid/in_ready/a/b/sub/cin
//           request channel, out_valid/out_ready/sum/cout/zero/neg/ovf
//           result channel
//
// Build option
//   NBIT_PIPE_FLAGS_EN  when defined, zero/neg/ovf are produced; otherwise
//                       no flag state is built and the three flags read 0.
//
// Subtraction is A + ~B + 1: B is inverted and the carry-in forced to 1 at
// stage 0, so every later stage only ever adds.
// Outputs are gated with the last-stage valid bit, which keeps sum and the
// flags at 0 whenever nothing is presented (including during reset) without
// resetting the datapath registers.
// ---------------------------------------------------------------------------
module nbit_pipe_addsub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    nbit_pipe_addsub_if.slave   p
);
    localparam int SEG  = N / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] take;
    logic              s0_rdy;
    logic              in_fire;

    // Stage k advances if every stage from k down to the output either
    // has a hole or the consumer accepts. Walking from the output towards
    // the input with an accumulator keeps this free of combinational loops.
    always_comb begin
        logic acc;
        acc = p.out_ready;
        adv = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = vld_q[k] & acc;
            acc    = ~vld_q[k] | acc;
        end
        s0_rdy = acc;
    end

    assign p.in_ready = ~rst & s0_rdy;
    assign in_fire    = p.in_valid & p.in_ready;

    // A stage loads when its upstream neighbour advances into it; stage 0
    // loads on an input transfer.
    always_comb begin
        take    = '0;
        take[0] = in_fire;
        for (int k = 1; k < STAGES; k++) begin
            take[k] = adv[k-1];
        end
        vld_d = (vld_q & ~adv) | take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be processed when entering this stage, and
        // result bits finished once this stage has registered.
        localparam int W_IN  = N - k * SEG;
        localparam int W_RES = (k + 1) * SEG;

        logic [W_IN-1:0]  a_in;
        logic [W_IN-1:0]  b_in;
        logic             c_in;
        logic [SEG:0]     seg_sum;
        logic [W_RES-1:0] res_d;
        logic [W_RES-1:0] res_q;
        logic             cy_q;

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                       + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_src
            assign a_in  = p.a;
            assign b_in  = p.sub ? ~p.b : p.b;
            assign c_in  = p.sub | p.cin;
            assign res_d = seg_sum[SEG-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_ops.a_q;
            assign b_in  = g_stage[k-1].g_ops.b_q;
            assign c_in  = g_stage[k-1].cy_q;
            assign res_d = {seg_sum[SEG-1:0], g_stage[k-1].res_q};
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (take[k]) begin
                res_q <= res_d;
                cy_q  <= seg_sum[SEG];
            end
        end

        // Upper operand bits travel on; the last stage has none left.
        if (k < LAST) begin : g_ops
            logic [W_IN-SEG-1:0] a_q;
            logic [W_IN-SEG-1:0] b_q;
            always_ff @(posedge clk) begin
                if (take[k]) begin
                    a_q <= a_in[W_IN-1:SEG];
                    b_q <= b_in[W_IN-1:SEG];
                end
            end
        end

`ifdef NBIT_PIPE_FLAGS_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        // The carry into the MSB is recovered from the MSB sum bit and the
        // two (already-inverted-for-subtract) operand sign bits.
        if (k == LAST) begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (take[k]) begin
                    ovf_q <= (seg_sum[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1])
                           ^ seg_sum[SEG];
                end
            end
        end
`endif
    end

    // ---- output (last stage) ----
    assign p.out_valid = vld_q[LAST];
    assign p.sum       = vld_q[LAST] ? g_stage[LAST].res_q : '0;
    assign p.cout      = vld_q[LAST] & g_stage[LAST].cy_q;

`ifdef NBIT_PIPE_FLAGS_EN
    assign p.zero = vld_q[LAST] & (g_stage[LAST].res_q == '0);
    assign p.neg  = vld_q[LAST] & g_stage[LAST].res_q[N-1];
    assign p.ovf  = vld_q[LAST] & g_stage[LAST].g_ovf.ovf_q;
`else
    assign p.zero = 1'b0;
    assign p.neg  = 1'b0;
    assign p.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_nbit_pipe_addsub.sv
`timescale 1ns/1ps
module tb_nbit_pipe_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nbit_pipe_addsub_if #(.N(32)) if32 ();
    nbit_pipe_addsub_if #(.N(8))  if8 ();

    nbit_pipe_addsub #(.N(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .p(if32));
    nbit_pipe_addsub #(.N(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .p(if8));

`ifdef NBIT_PIPE_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        z;
        logic        n;
        logic        o;
    } res_t;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] s, input logic c,
                         input logic z, input logic n, input logic o);
        chk({tag, ".sum"},  if32.sum,  s);
        chk({tag, ".cout"}, if32.cout, c);
        chk({tag, ".zero"}, if32.zero, z & FL);
        chk({tag, ".neg"},  if32.neg,  n & FL);
        chk({tag, ".ovf"},  if32.ovf,  o & FL);
    endtask

    // Flat 33-bit reference: A + (B or ~B) + carry-in.
    function automatic res_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic s, input logic ci);
        logic [32:0] w;
        logic [31:0] be;
        res_t r;
        be  = s ? ~b : b;
        w   = {1'b0, a} + {1'b0, be} + {32'd0, (s | ci)};
        r.s = w[31:0];
        r.c = w[32];
        r.z = (w[31:0] == 32'd0);
        r.n = w[31];
        r.o = (a[31] == be[31]) && (w[31] != a[31]);
        return r;
    endfunction

    // Called at a negedge with an empty pipe; returns at the negedge after
    // the accepting edge.
    task automatic send32(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic ci);
        if32.in_valid = 1'b1;
        if32.a = a; if32.b = b; if32.sub = s; if32.cin = ci;
        @(posedge clk);
        @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, input logic [31:0] es,
                        input logic ec, input logic ez, input logic en, input logic eo);
        chk({tag, ".in_ready"}, if32.in_ready, 1'b1);
        send32(a, b, s, ci);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".early"}, if32.out_valid, 1'b0);
        @(negedge clk);
        chk({tag, ".valid"}, if32.out_valid, 1'b1);
        chk32(tag, es, ec, ez, en, eo);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic ci, input logic [7:0] es,
                       input logic ec, input logic en, input logic eo);
        chk({tag, ".in_ready"}, if8.in_ready, 1'b1);
        if8.in_valid = 1'b1;
        if8.a = a; if8.b = b; if8.sub = s; if8.cin = ci;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        chk({tag, ".valid"}, if8.out_valid, 1'b1);
        chk({tag, ".sum"},   if8.sum,  es);
        chk({tag, ".cout"},  if8.cout, ec);
        chk({tag, ".neg"},   if8.neg,  en & FL);
        chk({tag, ".ovf"},   if8.ovf,  eo & FL);
        @(negedge clk);
        chk({tag, ".drained"}, if8.out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ta [8];
        logic [31:0] tb_v [8];
        logic        tsub [8];
        logic        tcin [8];
        res_t        q [$];
        res_t        r;
        int          sent, got, extra;
        logic        saw_stall, held, held_c;
        logic [31:0] held_s;

        rst = 1'b1;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        if32.a = '0; if32.b = '0; if32.sub = 1'b0; if32.cin = 1'b0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b1;
        if8.a = '0; if8.b = '0; if8.sub = 1'b0; if8.cin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", if32.in_ready, 1'b0);
        chk("rst.out_valid", if32.out_valid, 1'b0);
        chk32("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.in_ready8", if8.in_ready, 1'b0);
        chk("rst.out_valid8", if8.out_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel.in_ready", if32.in_ready, 1'b1);
        @(negedge clk);

        // Directed 32-bit vectors (hand-computed)
        op32("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        op32("sub_5_7",  32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        op32("sub_7_5",  32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
        op32("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        op32("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        op32("add_cin",  32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back random ops with a consumer stall
        for (int i = 0; i < 8; i++) begin
            ta[i] = $urandom; tb_v[i] = $urandom;
            tsub[i] = 1'($urandom_range(0, 1)); tcin[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; saw_stall = 1'b0; held = 1'b0; held_s = '0; held_c = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if32.out_ready = !(c >= 3 && c <= 6);
            if (sent < 8) begin
                if32.in_valid = 1'b1;
                if32.a = ta[sent]; if32.b = tb_v[sent];
                if32.sub = tsub[sent]; if32.cin = tcin[sent];
            end else begin
                if32.in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall.hold_sum", if32.sum, held_s);
                chk("stall.hold_cout", if32.cout, held_c);
            end
            if (if32.out_valid && if32.out_ready) begin
                if (q.size() == 0) begin
                    chk("stall.unexpected_out", 1'b1, 1'b0);
                end else begin
                    r = q.pop_front();
                    chk32("stall.res", r.s, r.c, r.z, r.n, r.o);
                    got++;
                end
            end
            held   = if32.out_valid && !if32.out_ready;
            held_s = if32.sum;
            held_c = if32.cout;
            if (if32.in_valid && if32.in_ready) begin
                q.push_back(model32(ta[sent], tb_v[sent], tsub[sent], tcin[sent]));
                sent++;
            end else if (if32.in_valid) begin
                // No transfer this cycle: garbage operands must be ignored.
                saw_stall = 1'b1;
                if32.a = $urandom; if32.b = $urandom;
            end
        end
        chk("stall.results", got, 8);
        chk("stall.in_ready_dropped", saw_stall, 1'b1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (if32.out_valid) extra++;
        end
        chk("stall.no_duplicates", extra, 0);

        // Reset with 3 ops in flight
        if32.out_ready = 1'b1;
        if32.sub = 1'b0; if32.cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if32.in_valid = 1'b1;
            if32.a = 32'h11111111 * (i + 1); if32.b = 32'h01010101;
            @(negedge clk);
        end
        if32.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid.in_ready", if32.in_ready, 1'b0);
        @(negedge clk);
        chk("rstmid.out_valid", if32.out_valid, 1'b0);
        rst = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (if32.out_valid) extra++;
        end
        chk("rstmid.no_stale", extra, 0);
        op32("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // N=8, STAGES=1
        op8("n8_add", 8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        op8("n8_sub", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/nbit_pipe_addsub.md
# nbit_pipe_addsub

Parametrised, pipelined N-bit adder/subtractor that splits the carry chain into STAGES registered segments, so wide arithmetic closes timing at one segment of ripple delay per cycle. It accepts one operation per cycle through a valid/ready handshake with full backpressure and returns sum, carry and optional status flags in issue order. It serves the RV32IM datapath as the arithmetic unit for multi-cycle ALU paths and the iterative multiply/divide sequencer.

## Interface
- N, 32, operand/result width; N >= 2.
- STAGES, 4, pipeline depth and number of carry-chain segments; STAGES >= 1; N % STAGES == 0; SEG = N/STAGES.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  1 = A - B, 0 = A + B + cin.
- cin  input  1  carry-in for add; ignored when sub=1.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result.
- cout  output  1  carry-out. For subtract, 1 = no borrow (A >= B unsigned).
- zero  output  1  sum == 0.
- neg  output  1  sum[N-1].
- ovf  output  1  signed overflow.

## Operation
- Effective operation: add computes A + B + cin. Subtract computes A + ~B + 1. Arithmetic is modulo 2^N. cout is bit N of the effective sum.
- Skewed pipeline. Stage k (0..STAGES-1) holds:
  - a valid bit;
  - result bits [k*SEG+SEG-1:0] finished so far;
  - the carry out of segment k;
  - the still-unprocessed upper operand bits (B already inverted for subtract);
  - the sign bits needed for ovf.
- Stage 0 registers the segment-0 result from the inputs. Stage k registers the segment-k result using the stage k-1 carry. Each stage ripples SEG bits only.
- ovf = carry into bit N-1 XOR carry out of bit N-1.
- Handshake:
  - A transfer in occurs when in_valid && in_ready.
  - A transfer out occurs when out_valid && out_ready.
  - out_valid equals the last stage's valid bit.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready.
  - in_ready = !rst && (stage 0 empty || stage 0 advancing).
- Bubbles collapse: an empty stage accepts regardless of downstream stalls.
- Results leave strictly in acceptance order, with no loss and no duplication.
- While out_valid && !out_ready, sum/cout/flags hold stable.
- Input data is sampled only on a transfer in. Operand changes while in_ready=0 have no effect.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, zero 0, neg 0, ovf 0, in_ready 0 while rst is high.
- in_ready is 1 in the first cycle after rst deasserts.
- Latency: an op accepted at edge t gives out_valid=1 after edge t+STAGES-1 (visible in cycle t+STAGES-1..t+STAGES), provided no stall occurs.
- STAGES=1 gives single-cycle registered latency.
- Throughput is 1 op/cycle while out_ready=1.
- Simultaneous transfer in and out with a full pipeline is permitted: stages shift and the new op is taken in the same cycle.
- Reset mid-operation: rst high at an edge invalidates all in-flight ops. No pre-reset result appears afterward.
- Flags are combinational from the last-stage register. No extra latency.

## Configuration
- NBIT_PIPE_FLAGS_EN defined: zero, neg and ovf are computed and carried through the pipeline as above.
- NBIT_PIPE_FLAGS_EN undefined: no flag or sign pipeline registers are built. zero, neg and ovf are tied to 0. Ports remain present. sum, cout, handshake and latency are unchanged.

## Test plan
- N=32, STAGES=4, add 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> after 4 cycles: sum 0x00000000, cout 1, zero 1, ovf 0.
- Subtract 0x00000005 - 0x00000007 -> sum 0xFFFFFFFE, cout 0, neg 1, ovf 0. Subtract 7 - 5 -> sum 0x00000002, cout 1.
- Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, ovf 1, neg 1, cout 0.
- Issue 8 back-to-back random ops with out_ready low in cycles 3-6 -> in_ready drops once all 4 stages fill. Outputs hold stable while stalled. All 8 results match the reference model, in order, with no duplicates.
- Accept 3 ops, assert rst for one cycle -> out_valid is 0 from the next cycle. None of the 3 results ever appear. A new op issued after reset returns correctly in 4 cycles.
- N=8, STAGES=1: add 0x80 + 0x80, cin=1 -> after 1 cycle: sum 0x01, cout 1, ovf 1.
- Rerun with NBIT_PIPE_FLAGS_EN undefined -> zero, neg and ovf are always 0.
